// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file with a busy-bit scoreboard. Writeback writes results
// in, decode reads two operands through registered read ports, and decode
// reserves destination registers so that RAW hazards can be flagged.
// x0 is hardwired to zero. All state updates happen on the rising clock edge
// under a synchronous, active-high reset.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   - a same-edge write is forwarded into a matching read port, and
//               the hazard for a register released by that write is masked.
//   undefined - reads return pre-write contents and the hazard uses busy_vec
//               as it stands this cycle.
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous active-high reset
//   wr_enable      in   writeback write strobe
//   wr_addr        in   writeback destination register
//   wr_data        in   writeback data
//   rd_en          in   decode read request
//   rs1_addr       in   read port 1 address
//   rs2_addr       in   read port 2 address
//   rs1_data       out  registered read data, port 1
//   rs2_data       out  registered read data, port 2
//   rd_data_valid  out  rs1_data/rs2_data valid this cycle
//   reserve_en     in   decode reserves reserve_addr as busy
//   reserve_addr   in   register being reserved
//   flush          in   clear all busy bits
//   hazard         out  combinational RAW hazard on rs1/rs2
//   busy_vec       out  busy bits, bit i = xi
// -----------------------------------------------------------------------------

`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef REG_DATA_SIZE
`define REG_DATA_SIZE 31
`endif

module regfile_scoreboard #(
  parameter int                    NUM_REGS    = 32,
  parameter logic [`REG_DATA_SIZE:0] RESET_VALUE = {(`REG_DATA_SIZE+1){1'b0}}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_enable,
  input  logic [`REG_ADDR_SIZE:0]   wr_addr,
  input  logic [`REG_DATA_SIZE:0]   wr_data,
  input  logic                      rd_en,
  input  logic [`REG_ADDR_SIZE:0]   rs1_addr,
  input  logic [`REG_ADDR_SIZE:0]   rs2_addr,
  output logic [`REG_DATA_SIZE:0]   rs1_data,
  output logic [`REG_DATA_SIZE:0]   rs2_data,
  output logic                      rd_data_valid,
  input  logic                      reserve_en,
  input  logic [`REG_ADDR_SIZE:0]   reserve_addr,
  input  logic                      flush,
  output logic                      hazard,
  output logic [NUM_REGS-1:0]       busy_vec
);

  localparam int AW = `REG_ADDR_SIZE + 1;
  localparam int DW = `REG_DATA_SIZE + 1;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // True for an address naming a real, writable register (x1..x(NUM_REGS-1)).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NUM_REGS) && (a != {AW{1'b0}});
  endfunction

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DW-1:0]       rs1_q, rs1_d, rs2_q, rs2_d;
  logic                valid_q, valid_d;

  logic                wr_hit_s;
  logic                byp1_s, byp2_s;
  logic                rs1_busy_s, rs2_busy_s;

  assign wr_hit_s = wr_enable && addr_ok(wr_addr);
  // Forwarding only exists with the bypass build; otherwise these stay low.
  assign byp1_s   = BYPASS && wr_hit_s && (wr_addr == rs1_addr);
  assign byp2_s   = BYPASS && wr_hit_s && (wr_addr == rs2_addr);

  // Read-port next state: load on rd_en, otherwise hold the last data.
  always_comb begin
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    valid_d = rd_en;
    if (rd_en) begin
      if (!addr_ok(rs1_addr)) begin
        rs1_d = {DW{1'b0}};
      end else if (byp1_s) begin
        rs1_d = wr_data;
      end else begin
        rs1_d = regs_q[rs1_addr];
      end
      if (!addr_ok(rs2_addr)) begin
        rs2_d = {DW{1'b0}};
      end else if (byp2_s) begin
        rs2_d = wr_data;
      end else begin
        rs2_d = regs_q[rs2_addr];
      end
    end else begin
      rs1_d = rs1_q;
      rs2_d = rs2_q;
    end
  end

  // Scoreboard next state: clear (flush or write release), then reserve,
  // so a same-cycle reserve always wins over any clear.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = {NUM_REGS{1'b0}};
    end else if (wr_hit_s) begin
      busy_d[wr_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (reserve_en && addr_ok(reserve_addr)) begin
      busy_d[reserve_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Hazard per port; a register being released this cycle is not a hazard
  // when its value is forwarded.
  always_comb begin
    rs1_busy_s = addr_ok(rs1_addr) && busy_q[rs1_addr] && !byp1_s;
    rs2_busy_s = addr_ok(rs2_addr) && busy_q[rs2_addr] && !byp2_s;
  end

  assign hazard = rd_en && (rs1_busy_s || rs2_busy_s);

  // Register array storage; entry 0 is never written and never read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0) begin
          regs_q[i] <= {DW{1'b0}};
        end else begin
          regs_q[i] <= RESET_VALUE;
        end
      end
    end else if (wr_hit_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read-port and scoreboard state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_q   <= {DW{1'b0}};
      rs2_q   <= {DW{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= {NUM_REGS{1'b0}};
    end else begin
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rs1_data      = rs1_q;
  assign rs2_data      = rs2_q;
  assign rd_data_valid = valid_q;
  assign busy_vec      = busy_q;

endmodule
